// File: rtl/fetch_seq6809.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : fetch_seq6809
// Purpose  : 6809 instruction fetch sequencer. Runs vector fetch, opcode and
//            page-prefix capture, and big-endian operand assembly.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_seq6809 #(
  parameter int          ADDR_W    = 16,
  parameter logic [15:0] RESET_VEC = 16'hFFFE,
  parameter logic [15:0] VEC_BASE  = 16'hFFF0,
  parameter int          MAX_OPND  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic [ADDR_W-1:0]     addr,
  input  logic [7:0]            data_in,
  input  logic [2:0]            opnd_len,
  output logic [7:0]            ir_o,
  output logic [7:0]            pb_o,
  output logic                  has_pb_o,
  output logic [8*MAX_OPND-1:0] opnd_o,
  output logic [ADDR_W-1:0]     inst_pc_o,
  output logic [ADDR_W-1:0]     pc_o,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  input  logic                  load_pc,
  input  logic [ADDR_W-1:0]     new_pc,
  input  logic                  vec_req,
  input  logic [2:0]            vec_sel,
  input  logic                  halt_b,
  output logic                  halted
);

  localparam int c_OPND_W = 8 * MAX_OPND;

  typedef enum logic [2:0] {
    S_RST  = 3'd0,
    S_VHI  = 3'd1,
    S_VLO  = 3'd2,
    S_OPC  = 3'd3,
    S_PFX  = 3'd4,
    S_OPND = 3'd5,
    S_PRES = 3'd6,
    S_HALT = 3'd7
  } state_t;

  state_t                r_state;
  logic [ADDR_W-1:0]     r_addr;
  logic [ADDR_W-1:0]     r_pc;
  logic [ADDR_W-1:0]     r_inst_pc;
  logic [7:0]            r_ir;
  logic [7:0]            r_pb;
  logic                  r_has_pb;
  logic [c_OPND_W-1:0]   r_opnd;
  logic                  r_valid;
  logic                  r_halted;
  logic [7:0]            r_vhi;
  logic [2:0]            r_len;
  logic [2:0]            r_cnt;
  logic                  r_opnd_first;

  logic [ADDR_W-1:0]     w_addr_inc;
  logic [ADDR_W-1:0]     w_vec_addr;
  logic [ADDR_W-1:0]     w_vec_pc;
  logic [2:0]            w_len;
  logic [2:0]            w_cnt_nxt;
  logic [c_OPND_W-1:0]   w_opnd_base;
  logic                  w_is_pfx;
  logic                  w_hs;
  logic                  w_take_vec;
  logic                  w_take_load;

  assign w_addr_inc  = r_addr + ADDR_W'(1);
  assign w_vec_addr  = ADDR_W'(VEC_BASE) + ADDR_W'({vec_sel, 1'b0});
  assign w_vec_pc    = ADDR_W'({r_vhi, data_in});
  // opnd_len is only trusted on the first operand cycle; later cycles use the latched copy
  assign w_len       = r_opnd_first ? opnd_len : r_len;
  assign w_cnt_nxt   = r_opnd_first ? 3'd1 : (r_cnt + 3'd1);
  assign w_opnd_base = r_opnd_first ? '0 : (r_opnd << 8);
  assign w_is_pfx    = (data_in == 8'h10) || (data_in == 8'h11);
  assign w_hs        = r_valid && inst_ready;

  assign w_take_vec  = vec_req && (((r_state == S_PRES) && w_hs) || (r_state == S_HALT));
  assign w_take_load = load_pc && !w_take_vec &&
                       ((r_state == S_OPC) || (r_state == S_PFX) || (r_state == S_OPND) ||
                        (r_state == S_PRES) || (r_state == S_HALT));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_RST;
      r_addr       <= ADDR_W'(RESET_VEC);
      r_pc         <= '0;
      r_inst_pc    <= '0;
      r_ir         <= 8'h00;
      r_pb         <= 8'h00;
      r_has_pb     <= 1'b0;
      r_opnd       <= '0;
      r_valid      <= 1'b0;
      r_halted     <= 1'b0;
      r_vhi        <= 8'h00;
      r_len        <= 3'd0;
      r_cnt        <= 3'd0;
      r_opnd_first <= 1'b0;
    end else if (w_take_vec) begin
      r_addr   <= w_vec_addr;
      r_valid  <= 1'b0;
      r_halted <= 1'b0;
      r_state  <= S_VHI;
    end else if (w_take_load) begin
      r_addr   <= new_pc;
      r_pc     <= new_pc;
      r_valid  <= 1'b0;
      r_halted <= 1'b0;
      r_state  <= S_OPC;
    end else begin
      case (r_state)
        S_RST: r_state <= S_VHI;
        S_VHI: begin
          r_vhi   <= data_in;
          r_addr  <= w_addr_inc;
          r_state <= S_VLO;
        end
        S_VLO: begin
          r_pc    <= w_vec_pc;
          r_addr  <= w_vec_pc;
          r_state <= S_OPC;
        end
        S_OPC: begin
          r_ir         <= data_in;
          r_inst_pc    <= r_addr;
          r_has_pb     <= 1'b0;
          r_addr       <= w_addr_inc;
          r_pc         <= w_addr_inc;
          r_opnd_first <= 1'b1;
          r_state      <= w_is_pfx ? S_PFX : S_OPND;
        end
        S_PFX: begin
          r_pb     <= data_in;
          r_has_pb <= 1'b1;
          r_addr   <= w_addr_inc;
          r_pc     <= w_addr_inc;
          r_state  <= S_OPND;
        end
        S_OPND: begin
          r_opnd_first <= 1'b0;
          if (r_opnd_first) r_len <= opnd_len;
          if (w_len == 3'd0) begin
            r_opnd  <= '0;
            r_valid <= 1'b1;
            r_state <= S_PRES;
          end else begin
            r_opnd <= w_opnd_base | c_OPND_W'(data_in);
            r_addr <= w_addr_inc;
            r_pc   <= w_addr_inc;
            r_cnt  <= w_cnt_nxt;
            if (w_cnt_nxt == w_len) begin
              r_valid <= 1'b1;
              r_state <= S_PRES;
            end
          end
        end
        S_PRES: begin
          if (w_hs) begin
            r_valid <= 1'b0;
            if (!halt_b) begin
              r_halted <= 1'b1;
              r_state  <= S_HALT;
            end else begin
              r_addr  <= r_pc;
              r_state <= S_OPC;
            end
          end
        end
        S_HALT: begin
          if (halt_b) begin
            r_halted <= 1'b0;
            r_addr   <= r_pc;
            r_state  <= S_OPC;
          end
        end
        default: r_state <= S_RST;
      endcase
    end
  end

  assign addr       = r_addr;
  assign ir_o       = r_ir;
  assign pb_o       = r_pb;
  assign has_pb_o   = r_has_pb;
  assign opnd_o     = r_opnd;
  assign inst_pc_o  = r_inst_pc;
  assign pc_o       = r_pc;
  assign inst_valid = r_valid;
  assign halted     = r_halted;

endmodule
`default_nettype wire

// File: tb/tb_fetch_seq6809.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_fetch_seq6809
// Purpose  : Bench for fetch_seq6809 with an instruction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_seq6809;

  localparam logic [15:0] c_RESET_VEC = 16'hFFFE;
  localparam logic [15:0] c_VEC_BASE  = 16'hFFF0;
  localparam int c_P_RST = 0, c_P_VEC = 1, c_P_FET = 2, c_P_PRES = 3, c_P_HALT = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] addr;
  logic [7:0]  data_in;
  logic [2:0]  opnd_len;
  logic [7:0]  ir_o, pb_o;
  logic        has_pb_o;
  logic [15:0] opnd_o, inst_pc_o, pc_o;
  logic        inst_valid, halted;
  logic        inst_ready = 1'b0, load_pc = 1'b0, vec_req = 1'b0, halt_b = 1'b1;
  logic [15:0] new_pc = 16'h0000;
  logic [2:0]  vec_sel = 3'd0;

  logic [7:0]  mem [0:65535];
  int          vectors = 0;
  int          miscompares = 0;
  logic        run = 1'b0;

  // reference model state: instruction-level view of the fetch stream
  int          m_phase = c_P_RST;
  int          m_vj, m_i;
  logic [15:0] m_vaddr, m_s, m_pc = 16'h0000;
  logic [7:0]  m_vhi;
  logic [7:0]  f_ir, f_pb;
  logic        f_has;
  int          f_len, f_total, f_cycles;
  logic [15:0] f_opnd;
  logic [15:0] e_addr, e_pc;

  always #5 clk = ~clk;

  fetch_seq6809 dut (
    .clk(clk), .reset(reset), .addr(addr), .data_in(data_in), .opnd_len(opnd_len),
    .ir_o(ir_o), .pb_o(pb_o), .has_pb_o(has_pb_o), .opnd_o(opnd_o),
    .inst_pc_o(inst_pc_o), .pc_o(pc_o), .inst_valid(inst_valid),
    .inst_ready(inst_ready), .load_pc(load_pc), .new_pc(new_pc),
    .vec_req(vec_req), .vec_sel(vec_sel), .halt_b(halt_b), .halted(halted)
  );

  function automatic logic [2:0] dec(input logic [7:0] ir, input logic [7:0] pb, input logic has);
    if (has) return (pb == 8'h8E) ? 3'd2 : 3'(pb % 3);
    return 3'(ir % 3);
  endfunction

  assign data_in  = mem[addr];
  assign opnd_len = dec(ir_o, pb_o, has_pb_o);

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic load_info(input logic [15:0] s);
    logic [15:0] p;
    f_ir  = mem[s];
    f_has = (f_ir == 8'h10) || (f_ir == 8'h11);
    f_pb  = 8'h00;
    p     = s + 16'd1;
    if (f_has) begin
      f_pb = mem[p];
      p    = p + 16'd1;
    end
    f_len  = int'(dec(f_ir, f_pb, f_has));
    f_opnd = 16'h0000;
    for (int k = 0; k < f_len; k++) begin
      f_opnd = (f_opnd << 8) | {8'h00, mem[p]};
      p      = p + 16'd1;
    end
    f_total  = 1 + int'(f_has) + f_len;
    f_cycles = 1 + int'(f_has) + ((f_len == 0) ? 1 : f_len);
    m_s      = s;
    m_i      = 0;
    m_phase  = c_P_FET;
  endtask

  task automatic start_vec();
    m_pc    = m_s + 16'(f_total);
    m_vaddr = c_VEC_BASE + {12'd0, vec_sel, 1'b0};
    m_vj    = 0;
    m_phase = c_P_VEC;
  endtask

  task automatic model_step();
    if (reset) begin
      m_phase = c_P_RST;
      m_pc    = 16'h0000;
    end else begin
      case (m_phase)
        c_P_RST: begin
          m_phase = c_P_VEC; m_vaddr = c_RESET_VEC; m_vj = 0;
        end
        c_P_VEC: begin
          if (m_vj == 0) begin
            m_vhi = mem[m_vaddr];
            m_vj  = 1;
          end else begin
            load_info({m_vhi, mem[m_vaddr + 16'd1]});
          end
        end
        c_P_FET: begin
          if (load_pc) load_info(new_pc);
          else begin
            m_i++;
            if (m_i == f_cycles) m_phase = c_P_PRES;
          end
        end
        c_P_PRES: begin
          if (inst_ready && vec_req) start_vec();
          else if (load_pc) load_info(new_pc);
          else if (inst_ready) begin
            if (!halt_b) m_phase = c_P_HALT;
            else load_info(m_s + 16'(f_total));
          end
        end
        default: begin
          if (vec_req) start_vec();
          else if (load_pc) load_info(new_pc);
          else if (halt_b) load_info(m_s + 16'(f_total));
        end
      endcase
    end
  endtask

  always @(negedge clk) begin
    if (run) begin
      vectors++;
      case (m_phase)
        c_P_RST: begin e_addr = c_RESET_VEC; e_pc = 16'h0000; end
        c_P_VEC: begin e_addr = m_vaddr + 16'(m_vj); e_pc = m_pc; end
        c_P_FET: begin
          e_addr = m_s + 16'((m_i < f_total) ? m_i : f_total);
          e_pc   = e_addr;
        end
        default: begin e_addr = m_s + 16'(f_total); e_pc = e_addr; end
      endcase
      check("addr", addr, e_addr);
      check("pc_o", pc_o, e_pc);
      check("inst_valid", inst_valid, m_phase == c_P_PRES);
      check("halted", halted, m_phase == c_P_HALT);
      if (m_phase == c_P_PRES) begin
        check("ir_o", ir_o, f_ir);
        check("inst_pc_o", inst_pc_o, m_s);
        check("has_pb_o", has_pb_o, f_has);
        check("opnd_o", opnd_o, f_opnd);
        if (f_has) check("pb_o", pb_o, f_pb);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic wait_valid(input string nm);
    int n;
    n = 0;
    while (!inst_valid && n < 12) begin
      step();
      n++;
    end
    if (!inst_valid) check({nm, "_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    for (int a = 0; a < 65536; a++) begin
      mem[a] = 8'($urandom);
      if ($urandom_range(0, 5) == 0) mem[a] = 8'h10 | 8'($urandom_range(0, 1));
    end
    mem[16'hFFFE] = 8'h12; mem[16'hFFFF] = 8'h34; mem[16'h1234] = 8'h12;
    mem[16'h2000] = 8'h10; mem[16'h2001] = 8'h8E; mem[16'h2002] = 8'hAB;
    mem[16'h2003] = 8'hCD; mem[16'h2004] = 8'h86; mem[16'h4000] = 8'h12;
    mem[16'hFFF6] = 8'hFF; mem[16'hFFF7] = 8'hFE; mem[16'h0000] = 8'h56;

    run = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_addr", addr, 16'hFFFE);
    check("rst_pc", pc_o, 16'h0000);
    check("rst_ir", ir_o, 8'h00);
    check("rst_opnd", opnd_o, 16'h0000);
    check("rst_inst_pc", inst_pc_o, 16'h0000);
    check("rst_valid", inst_valid, 1'b0);
    check("rst_halted", halted, 1'b0);
    reset = 1'b0;

    // boot through the reset vector to a zero-operand NOP
    step(); check("t1_addr_vhi", addr, 16'hFFFE);
    step(); check("t1_addr_vlo", addr, 16'hFFFF);
    step(); check("t1_addr_opc", addr, 16'h1234);
    mem[16'hFFFE] = 8'h86;
    step(); check("t1_valid_early", inst_valid, 1'b0);
    step();
    check("t1_valid", inst_valid, 1'b1);
    check("t1_ir", ir_o, 8'h12);
    check("t1_inst_pc", inst_pc_o, 16'h1234);
    check("t1_pc", pc_o, 16'h1235);

    // prefixed instruction with two operand bytes
    inst_ready = 1'b1; load_pc = 1'b1; new_pc = 16'h2000;
    step();
    inst_ready = 1'b0; load_pc = 1'b0;
    wait_valid("t2");
    check("t2_has_pb", has_pb_o, 1'b1);
    check("t2_pb", pb_o, 8'h8E);
    check("t2_opnd", opnd_o, 16'hABCD);
    check("t2_pc", pc_o, 16'h2004);

    // stall in presentation
    for (int k = 0; k < 5; k++) begin
      step();
      check("t3_hold_valid", inst_valid, 1'b1);
      check("t3_hold_opnd", opnd_o, 16'hABCD);
      check("t3_hold_addr", addr, 16'h2004);
    end
    inst_ready = 1'b1;
    step();
    inst_ready = 1'b0;
    check("t3_next_addr", addr, 16'h2004);
    check("t3_valid_drop", inst_valid, 1'b0);

    // redirect during the first operand byte
    step();
    load_pc = 1'b1; new_pc = 16'h4000;
    step();
    load_pc = 1'b0;
    check("t4_addr", addr, 16'h4000);
    check("t4_valid", inst_valid, 1'b0);
    wait_valid("t4");
    check("t4_inst_pc", inst_pc_o, 16'h4000);

    // vector beats redirect and halt; target wraps across FFFF
    vec_req = 1'b1; load_pc = 1'b1; new_pc = 16'h1111; halt_b = 1'b0; vec_sel = 3'd3;
    inst_ready = 1'b1;
    step();
    vec_req = 1'b0; load_pc = 1'b0; halt_b = 1'b1; inst_ready = 1'b0;
    check("t5_addr_vhi", addr, 16'hFFF6);
    step(); check("t5_addr_vlo", addr, 16'hFFF7);
    step(); check("t5_addr_opc", addr, 16'hFFFE);
    wait_valid("t6");
    check("t6_ir", ir_o, 8'h86);
    check("t6_opnd", opnd_o, 16'h3456);
    check("t6_pc_wrap", pc_o, 16'h0001);

    halt_b = 1'b0; inst_ready = 1'b1;
    step();
    inst_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("t6_halted", halted, 1'b1);
      step();
    end
    halt_b = 1'b1;
    step();
    check("t6_unhalt", halted, 1'b0);
    check("t6_unhalt_addr", addr, 16'h0001);

    for (int c = 0; c < 3000; c++) begin
      inst_ready = ($urandom_range(0, 9) < 7);
      load_pc    = ($urandom_range(0, 29) == 0);
      new_pc     = 16'($urandom);
      vec_req    = ($urandom_range(0, 19) == 0);
      vec_sel    = 3'($urandom);
      halt_b     = ($urandom_range(0, 9) != 0);
      if (c % 1000 == 999) begin
        reset   = 1'b1;
        m_phase = c_P_RST;
        m_pc    = 16'h0000;
        step();
        reset = 1'b0;
      end else begin
        step();
      end
    end

    @(posedge clk);
    run = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
